rca_accumulator: RTL and testbench

Sequential multi-operand accumulator that sits directly downstream of the 32-bit ripple-carry adder `rca_Nbit`. It accepts a stream of unsigned operands over a valid/ready handshake and feeds the running total and each new operand into `rca_Nbit`. It registers the adder's sum and, after `N_OPS` operands, presents the final total with a sticky wrap-around flag on an output valid/ready handshake.

---
 rtl/rca_pkg.sv | 21 ++
 rtl/rca_Nbit.sv | 35 +++
 rtl/rca_accumulator.sv | 115 +++++++++++
 tb/tb_rca_accumulator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared types and constants for the rca accumulator slice
//
// Purpose : FSM state encoding, native adder width and default burst length
//           shared by rca_Nbit and rca_accumulator.
// Ports   : none (package).

package rca_pkg;

   // Native width of the ripple-carry adder datapath.
   localparam int RCA_WIDTH = 32;

   // Default number of operands summed per burst.
   localparam int RCA_N_OPS = 4;

   // Accumulator FSM states.
   typedef enum logic {
      ACCUM = 1'b0,   // collecting operands, in_ready=1
      DONE  = 1'b1    // presenting total, out_valid=1
   } acc_state_t;

endpackage : rca_pkg

// File: rtl/rca_Nbit.sv
// rtl/rca_Nbit.sv - combinational N-bit ripple-carry adder, no carry in/out
//
// Purpose : c = a + b modulo 2^WIDTH, built as a chain of full adders.
// Ports   :
//   a  in  WIDTH  first addend
//   b  in  WIDTH  second addend
//   c  out WIDTH  sum, carry out of the top bit is dropped

module rca_Nbit
   import rca_pkg::*;
#(
   parameter int WIDTH = RCA_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c
);

   // carry[i] is the carry into bit i. The carry out of the top bit is never
   // formed, so the chain stops at WIDTH-1.
   logic [WIDTH-1:0] carry;

   assign carry[0] = 1'b0;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         assign c[i] = a[i] ^ b[i] ^ carry[i];
         if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
         end
      end
   endgenerate

endmodule : rca_Nbit

// File: rtl/rca_accumulator.sv
// rtl/rca_accumulator.sv - multi-operand burst accumulator around rca_Nbit
//
// Purpose : Sums N_OPS unsigned operands received over a valid/ready stream
//           and presents the total plus a sticky wrap flag on an output
//           valid/ready handshake.
// Ports   :
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous abort of the current burst
//   in_data    in   WIDTH  operand
//   in_valid   in   1      operand valid
//   in_ready   out  1      operand can be accepted
//   out_sum    out  WIDTH  burst total modulo 2^WIDTH
//   out_ovf    out  1      at least one unsigned wrap in this burst
//   out_valid  out  1      out_sum/out_ovf valid
//   out_ready  in   1      consumer accepts the result

module rca_accumulator
   import rca_pkg::*;
#(
   parameter int WIDTH = RCA_WIDTH,
   parameter int N_OPS = RCA_N_OPS,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   // Counter value at which the current accept is the last of the burst.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

   acc_state_t       state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic [WIDTH-1:0] sum_next;
   logic             accept;
   logic             release_out;

   rca_Nbit #(
      .WIDTH (WIDTH)
   ) u_rca (
      .a (acc),
      .b (in_data),
      .c (sum_next)
   );

   assign accept      = in_valid & in_ready;
   assign release_out = out_valid & out_ready;

   // The adder has no carry out, so a wrap shows up as the new sum being
   // smaller than the running total it was built from.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else if (clear) begin
         // Abort wins over any simultaneous accept or output handshake.
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= sum_next;
                  ovf <= ovf | (sum_next < acc);
                  if (cnt == LAST_CNT) begin
                     cnt       <= '0;
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               // in_ready only returns the cycle after the result is taken.
               if (release_out) begin
                  state     <= ACCUM;
                  acc       <= '0;
                  ovf       <= 1'b0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ACCUM;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_sum = acc;
   assign out_ovf = ovf;

endmodule : rca_accumulator

// File: tb/tb_rca_accumulator.sv
// tb/tb_rca_accumulator.sv - directed self-checking bench for rca_accumulator

module tb_rca_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_sum;
   logic        out_ovf;
   logic        out_valid;
   logic        out_ready;

   int vectors = 0;
   int miscompares = 0;

   rca_accumulator #(
      .WIDTH (32),
      .N_OPS (4),
      .CNT_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Four back-to-back operands; ends #1 after the 4th accepting edge.
   task automatic burst4(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3,
                         input logic [31:0] exp_sum, input logic exp_ovf);
      logic [31:0] v [4];
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
         in_valid = 1'b1;
         in_data  = v[i];
         tick();
         if (i < 3) check({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
      end
      in_valid = 1'b0;
      check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_busy"}, {31'b0, in_ready}, 32'd0);
      check({tag, "_sum"}, out_sum, exp_sum);
      check({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, exp_ovf});
   endtask

   // Result taken on the next edge with out_ready=1.
   task automatic drain(input string tag);
      out_ready = 1'b1;
      tick();
      check({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      int accepts;
      logic [31:0] gap_data [7];
      logic        gap_vld  [7];

      rst_n     = 1'b0;
      clear     = 1'b0;
      in_data   = 32'd0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_sum", out_sum, 32'd0);
      check("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic sum.
      burst4("basic", 32'd10, 32'd9, 32'd586, 32'd298, 32'd903, 1'b0);
      drain("basic");

      // Wrap, then flag must clear for the next burst.
      burst4("wrap", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd1, 1'b1);
      drain("wrap");
      burst4("after_wrap", 32'd1, 32'd1, 32'd1, 32'd1, 32'd4, 1'b0);
      drain("after_wrap");

      // Backpressure with a pending operand 7 that must not be taken.
      out_ready = 1'b0;
      burst4("bp", 32'hFFFF_FFF0, 32'd2, 32'd3, 32'h20, 32'h15, 1'b1);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'd7;
         tick();
         check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
         check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_hold_sum", out_sum, 32'h15);
         check("bp_hold_ovf", {31'b0, out_ovf}, 32'd1);
      end
      in_valid = 1'b0;
      drain("bp");
      check("bp_acc_cleared", out_sum, 32'd0);

      // Gaps: 5 _ _ 6 _ 7 8.
      gap_data[0] = 32'd5; gap_vld[0] = 1'b1;
      gap_data[1] = 32'd99; gap_vld[1] = 1'b0;
      gap_data[2] = 32'd99; gap_vld[2] = 1'b0;
      gap_data[3] = 32'd6; gap_vld[3] = 1'b1;
      gap_data[4] = 32'd99; gap_vld[4] = 1'b0;
      gap_data[5] = 32'd7; gap_vld[5] = 1'b1;
      gap_data[6] = 32'd8; gap_vld[6] = 1'b1;
      accepts = 0;
      for (int i = 0; i < 7; i++) begin
         in_valid = gap_vld[i];
         in_data  = gap_data[i];
         if (in_valid && in_ready) accepts++;
         tick();
         if (i < 6) check("gap_early_valid", {31'b0, out_valid}, 32'd0);
      end
      in_valid = 1'b0;
      check("gap_accepts", accepts, 32'd4);
      check("gap_out_valid", {31'b0, out_valid}, 32'd1);
      check("gap_sum", out_sum, 32'd26);
      drain("gap");

      // Clear during a burst discards both the partial sum and operand 100.
      in_valid = 1'b1;
      in_data  = 32'd3;
      tick();
      in_data  = 32'd4;
      tick();
      check("clr_partial", out_sum, 32'd7);
      in_data  = 32'd100;
      clear    = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clr_sum", out_sum, 32'd0);
      check("clr_out_valid", {31'b0, out_valid}, 32'd0);
      check("clr_in_ready", {31'b0, in_ready}, 32'd1);
      burst4("post_clr", 32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 1'b0);
      drain("post_clr");

      // Asynchronous reset mid-cycle after three accepts.
      in_valid = 1'b1;
      in_data  = 32'd1;
      tick();
      in_data  = 32'd2;
      tick();
      in_data  = 32'd3;
      tick();
      in_valid = 1'b0;
      check("arst_before", out_sum, 32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sum", out_sum, 32'd0);
      check("arst_ovf", {31'b0, out_ovf}, 32'd0);
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      burst4("post_rst", 32'd1, 32'd1, 32'd1, 32'd1, 32'd4, 1'b0);
      drain("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_rca_accumulator
